// File: rtl/digit_pkg.sv
// Shared constants and state encoding for the multiplexed digit scanner.
package digit_pkg;

  localparam int DIGIT_W       = 4;
  localparam int DWELL_DEFAULT = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ONES = 2'd1,
    TENS = 2'd2
  } state_t;

endpackage

// File: rtl/digit_scan_ctrl_timer.sv
// Dwell counter: counts 0..DWELL-1, restart forces 0, done flags the last count.
module scan_timer #(
  parameter int DWELL = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic done
);

  logic [7:0] cnt_q, cnt_d;

  assign done = (cnt_q == 8'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart || done) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed two-digit decimal display scanner sharing one external decoder.
// Optional leading-zero blanking of the tens digit with DIGIT_SCAN_LZB_EN.
module digit_scan_ctrl
  import digit_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DWELL  = DWELL_DEFAULT,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [DIGIT_W-1:0]  wr_value,
  output logic [DIGIT_W-1:0]  dec_v,
  input  logic                dec_z,
  input  logic [DIGIT_W-1:0]  dec_m,
  output logic [2*NUM_CH-1:0] anode,
  output logic [DIGIT_W-1:0]  digit
);

  state_t              state_q;
  logic [CH_W-1:0]     cur_q;
  logic [DIGIT_W-1:0]  value_q [NUM_CH];
  logic                tens_q;
  logic [DIGIT_W-1:0]  ones_q;
  logic [2*NUM_CH-1:0] anode_q;
  logic [DIGIT_W-1:0]  digit_q;
  logic                wr_ready_q;

  logic                done;
  logic                restart;
  logic [2*NUM_CH-1:0] ones_an_d, tens_an_d;
  logic                tens_lit_d;

  assign restart  = (state_q == LOAD) || done;
  assign dec_v    = value_q[cur_q];
  assign anode    = anode_q;
  assign digit    = digit_q;
  assign wr_ready = wr_ready_q;

  scan_timer #(.DWELL(DWELL)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .done    (done)
  );

  always_comb begin
    ones_an_d = '0;
    tens_an_d = '0;
    ones_an_d[{cur_q, 1'b0}] = 1'b1;
    tens_an_d[{cur_q, 1'b1}] = 1'b1;
`ifdef DIGIT_SCAN_LZB_EN
    tens_lit_d = tens_q;
`else
    tens_lit_d = 1'b1;
`endif
  end

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      cur_q      <= '0;
      tens_q     <= 1'b0;
      ones_q     <= '0;
      anode_q    <= '0;
      digit_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          tens_q     <= dec_z;
          ones_q     <= dec_m;
          state_q    <= ONES;
          anode_q    <= ones_an_d;
          digit_q    <= dec_m;
          wr_ready_q <= 1'b1;
        end
        ONES: begin
          if (done) begin
            state_q <= TENS;
            anode_q <= tens_lit_d ? tens_an_d : '0;
            digit_q <= tens_lit_d ? {{(DIGIT_W-1){1'b0}}, tens_q} : '0;
          end
        end
        TENS: begin
          if (done) begin
            state_q    <= LOAD;
            cur_q      <= cur_q + 1'b1;
            anode_q    <= '0;
            digit_q    <= '0;
            wr_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= LOAD;
          anode_q    <= '0;
          digit_q    <= '0;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Displayed digits come from ones_q/tens_q, so a write to the lit channel waits for its next LOAD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) value_q[i] <= '0;
    end else if (wr_valid && wr_ready_q) begin
      value_q[wr_ch] <= wr_value;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl at NUM_CH=4, DWELL=16 (frame of 132 cycles).
module tb_digit_scan_ctrl;

`ifdef DIGIT_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_ch = '0;
  logic [3:0] wr_value = '0;
  logic [3:0] dec_v;
  logic       dec_z;
  logic [3:0] dec_m;
  logic [7:0] anode;
  logic [3:0] digit;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  always #5 clock = ~clock;

  // External decimal decoder
  assign dec_z = (dec_v > 4'd9);
  assign dec_m = (dec_v > 4'd9) ? dec_v - 4'd10 : dec_v;

  digit_scan_ctrl #(.NUM_CH(4), .DWELL(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_ch    (wr_ch),
    .wr_value (wr_value),
    .dec_v    (dec_v),
    .dec_z    (dec_z),
    .dec_m    (dec_m),
    .anode    (anode),
    .digit    (digit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc_n < c) begin
      @(negedge clock);
      cyc_n++;
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_anode", anode, 0);
    chk("rst_digit", digit, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_decv", dec_v, 0);

    // Idle scan, all values zero
    release_reset();
    chk("c0_load_anode", anode, 0);
    chk("c0_load_ready", wr_ready, 0);
    goto(1);
    chk("c1_ones_anode", anode, 8'h01);
    chk("c1_ones_ready", wr_ready, 1);
    chk("c1_ones_digit", digit, 0);

    // Write ch2 = 13 during ch0 ONES
    goto(2);
    wr_valid = 1'b1; wr_ch = 2'd2; wr_value = 4'd13;
    goto(3);
    wr_valid = 1'b0;
    goto(16);
    chk("c16_ones_anode", anode, 8'h01);
    goto(17);
    chk("c17_tens_anode", anode, LZB ? 8'h00 : 8'h02);
    chk("c17_tens_digit", digit, 0);
    goto(32);
    chk("c32_tens_anode", anode, LZB ? 8'h00 : 8'h02);
    goto(33);
    chk("c33_ch1_load_anode", anode, 0);
    chk("c33_ch1_load_ready", wr_ready, 0);
    goto(34);
    chk("c34_ch1_ones_anode", anode, 8'h04);
    goto(66);
    chk("c66_ch2_decv", dec_v, 13);
    goto(67);
    chk("c67_ch2_ones_anode", anode, 8'h10);
    chk("c67_ch2_ones_digit", digit, 3);
    goto(83);
    chk("c83_ch2_tens_anode", anode, 8'h20);
    chk("c83_ch2_tens_digit", digit, 1);

    // wr_valid held through ch3 LOAD
    goto(99);
    wr_valid = 1'b1; wr_ch = 2'd1; wr_value = 4'd5;
    chk("c99_load_ready", wr_ready, 0);
    goto(100);
    chk("c100_ones_ready", wr_ready, 1);
    chk("c100_ch3_anode", anode, 8'h40);
    goto(101);
    wr_valid = 1'b0;

    // ch1 = 5 displayed, then overwritten with 9 while lit
    goto(165);
    chk("c165_ch1_decv", dec_v, 5);
    goto(170);
    wr_valid = 1'b1; wr_ch = 2'd1; wr_value = 4'd9;
    goto(171);
    wr_valid = 1'b0;
    chk("c171_ch1_keep_anode", anode, 8'h04);
    chk("c171_ch1_keep_digit", digit, 5);
    goto(182);
    chk("c182_ch1_tens_anode", anode, LZB ? 8'h00 : 8'h08);
    chk("c182_ch1_tens_digit", digit, 0);
    goto(199);
    chk("c199_ch2_ones_digit", digit, 3);
    goto(297);
    chk("c297_ch1_decv", dec_v, 9);
    goto(298);
    chk("c298_ch1_ones_anode", anode, 8'h04);
    chk("c298_ch1_ones_digit", digit, 9);

    // ch0 = 7 (tens zero), later ch0 = 12
    goto(300);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_value = 4'd7;
    goto(301);
    wr_valid = 1'b0;
    goto(314);
    chk("c314_ch1_tens_anode", anode, LZB ? 8'h00 : 8'h08);
    goto(397);
    chk("c397_ch0_ones_digit", digit, 7);
    goto(413);
    chk("c413_ch0_tens_anode", anode, LZB ? 8'h00 : 8'h02);
    chk("c413_ch0_tens_digit", digit, 0);
    goto(420);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_value = 4'd12;
    goto(421);
    wr_valid = 1'b0;
    goto(428);
    chk("c428_ch0_tens_anode", anode, LZB ? 8'h00 : 8'h02);
    goto(430);
    wr_valid = 1'b1; wr_ch = 2'd3; wr_value = 4'd4;
    goto(431);
    wr_valid = 1'b0;
    goto(529);
    chk("c529_ch0_ones_anode", anode, 8'h01);
    chk("c529_ch0_ones_digit", digit, 2);
    goto(545);
    chk("c545_ch0_tens_anode", anode, 8'h02);
    chk("c545_ch0_tens_digit", digit, 1);

    // Reset mid-TENS of ch3 with a write pending
    goto(627);
    chk("c627_ch3_decv", dec_v, 4);
    goto(650);
    chk("c650_ch3_tens_anode", anode, 8'h80);
    wr_valid = 1'b1; wr_ch = 2'd1; wr_value = 4'd3;
    reset = 1'b1;
    #1;
    chk("arst_anode", anode, 0);
    chk("arst_digit", digit, 0);
    chk("arst_ready", wr_ready, 0);
    chk("arst_decv", dec_v, 0);
    @(negedge clock);
    wr_valid = 1'b0;
    release_reset();
    chk("r_c0_anode", anode, 0);
    chk("r_c0_decv", dec_v, 0);
    goto(1);
    chk("r_c1_anode", anode, 8'h01);
    chk("r_c1_digit", digit, 0);
    goto(33);
    chk("r_c33_ch1_decv", dec_v, 0);
    goto(66);
    chk("r_c66_ch2_decv", dec_v, 0);
    goto(99);
    chk("r_c99_ch3_decv", dec_v, 0);
    goto(100);
    chk("r_c100_ch3_anode", anode, 8'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
